// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the Runner timer/score counters.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] digit_t;

  // Non-decimal nibbles (A-F) are forced to 9 so the count stays valid BCD.
  function automatic digit_t bcd_clamp(input digit_t d);
    return (d > digit_t'(9)) ? digit_t'(9) : d;
  endfunction

endpackage

// File: rtl/bcd_counter_nd_if.sv
// Control/status bundle between the game FSM and the BCD counter.
interface bcd_counter_nd_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);

  localparam int W = BCD_W * DIGITS;

  logic         tick_in;
  logic         en;
  logic         pause;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] limit;
  logic [W-1:0] cnt;
  logic         tc;
  logic         done;

  modport master (
    output tick_in, en, pause, up, load, load_val, limit,
    input  cnt, tc, done
  );

  modport slave (
    input  tick_in, en, pause, up, load, load_val, limit,
    output cnt, tc, done
  );

endinterface

// File: rtl/bcd_digit.sv
// One decade of the counter: ripple carry on increment, ripple borrow on decrement.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  digit_t d,
  input  logic   inc,
  input  logic   dec,
  input  logic   carry_in,
  input  logic   borrow_in,
  output digit_t q,
  output digit_t nxt,
  output logic   carry_out,
  output logic   borrow_out
);

  assign carry_out  = inc & carry_in  & (q == digit_t'(9));
  assign borrow_out = dec & borrow_in & (q == digit_t'(0));

  always_comb begin
    nxt = q;
    if (inc && carry_in) begin
      nxt = (q == digit_t'(9)) ? digit_t'(0) : q + digit_t'(1);
    end else if (dec && borrow_in) begin
      nxt = (q == digit_t'(0)) ? digit_t'(9) : q - digit_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with tick edge detect, programmable limit,
// wrap or saturate at the ends, and a one-cycle done pulse.
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
)(
  input  logic             clk,
  input  logic             reset,
  bcd_counter_nd_if.slave  bus
);

  localparam int W = BCD_W * DIGITS;

  logic         tick_q;
  logic         done_q;
  logic         step;
  logic         at_top;
  logic         is_zero;
  logic         do_inc;
  logic         do_dec;
  logic         wrap_ld;
  logic         ld_any;
  logic [W-1:0] clamped;
  logic [W-1:0] ld_data;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_nxt;
  logic [DIGITS:0] carry;
  logic [DIGITS:0] borrow;
  logic         unused_chain;

  assign step    = bus.tick_in & ~tick_q & bus.en & ~bus.pause;
  assign at_top  = (cnt_q >= bus.limit);
  assign is_zero = (cnt_q == '0);

  // Load swallows any coincident tick, so stepping is gated by ~load.
  assign do_inc  = step & ~bus.load &  bus.up & ~at_top;
  assign do_dec  = step & ~bus.load & ~bus.up & ~is_zero;
  assign wrap_ld = WRAP & step & ~bus.load & (bus.up ? at_top : is_zero);
  assign ld_any  = bus.load | wrap_ld;
  assign ld_data = bus.load ? clamped : (bus.up ? '0 : bus.limit);

  assign carry[0]     = 1'b1;
  assign borrow[0]    = 1'b1;
  assign unused_chain = carry[DIGITS] ^ borrow[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign clamped[i*BCD_W +: BCD_W] = bcd_clamp(bus.load_val[i*BCD_W +: BCD_W]);

    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (ld_any),
      .d          (ld_data[i*BCD_W +: BCD_W]),
      .inc        (do_inc),
      .dec        (do_dec),
      .carry_in   (carry[i]),
      .borrow_in  (borrow[i]),
      .q          (cnt_q[i*BCD_W +: BCD_W]),
      .nxt        (cnt_nxt[i*BCD_W +: BCD_W]),
      .carry_out  (carry[i+1]),
      .borrow_out (borrow[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= bus.tick_in;
      done_q <= (do_inc && (cnt_nxt == bus.limit)) || (do_dec && (cnt_nxt == '0));
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.done = done_q;
  assign bus.tc   = (bus.up & at_top) | (~bus.up & is_zero);

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Directed bench for bcd_counter_nd: a wrapping and a saturating instance share stimulus.
module tb_bcd_counter_nd;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in, en, pause, up, load;
  logic [15:0] load_val, limit;
  int          n_tests = 0;
  int          n_fail  = 0;

  bcd_counter_nd_if #(.DIGITS(4)) b1 ();
  bcd_counter_nd_if #(.DIGITS(4)) b0 ();

  assign b1.tick_in = tick_in;  assign b0.tick_in = tick_in;
  assign b1.en = en;            assign b0.en = en;
  assign b1.pause = pause;      assign b0.pause = pause;
  assign b1.up = up;            assign b0.up = up;
  assign b1.load = load;        assign b0.load = load;
  assign b1.load_val = load_val; assign b0.load_val = load_val;
  assign b1.limit = limit;      assign b0.limit = limit;

  bcd_counter_nd #(.DIGITS(4), .WRAP(1'b1)) dut_wrap (.clk(clk), .reset(reset), .bus(b1));
  bcd_counter_nd #(.DIGITS(4), .WRAP(1'b0)) dut_sat  (.clk(clk), .reset(reset), .bus(b0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns on the negedge after the sampling posedge, when cnt/done are fresh.
  task automatic tick_once();
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk); load = 1'b1; load_val = v;
    @(negedge clk); load = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_cnt;
    reset = 1'b1; tick_in = 1'b0; en = 1'b0; pause = 1'b0; up = 1'b1;
    load = 1'b0; load_val = '0; limit = 16'h9999;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cnt", {16'h0, b1.cnt}, 32'h0);
    chk("rst_done", {31'h0, b1.done}, 32'h0);
    chk("rst_tc", {31'h0, b1.tc}, 32'h0);

    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick_once();
      exp_cnt = (i < 10) ? 16'(i) : 16'(16'h10 + (i - 10));
      chk($sformatf("up_%0d", i), {16'h0, b1.cnt}, {16'h0, exp_cnt});
      chk($sformatf("up_done_%0d", i), {31'h0, b1.done}, 32'h0);
    end

    do_load(16'h0999);
    chk("load_0999", {16'h0, b1.cnt}, 32'h0999);
    tick_once();
    chk("carry_1000", {16'h0, b1.cnt}, 32'h1000);
    do_load(16'h9998);
    tick_once();
    chk("top_9999", {16'h0, b1.cnt}, 32'h9999);
    chk("top_done", {31'h0, b1.done}, 32'h1);
    chk("top_tc", {31'h0, b1.tc}, 32'h1);
    @(negedge clk);
    chk("top_done_1clk", {31'h0, b1.done}, 32'h0);
    tick_once();
    chk("wrap_0000", {16'h0, b1.cnt}, 32'h0);
    chk("wrap_done0", {31'h0, b1.done}, 32'h0);
    chk("sat_hold_9999", {16'h0, b0.cnt}, 32'h9999);
    chk("sat_done0", {31'h0, b0.done}, 32'h0);

    up = 1'b0;
    do_load(16'h1000);
    tick_once();
    chk("borrow_0999", {16'h0, b1.cnt}, 32'h0999);

    limit = 16'h0059;
    do_load(16'h0001);
    tick_once();
    chk("dn_zero", {16'h0, b1.cnt}, 32'h0);
    chk("dn_done", {31'h0, b1.done}, 32'h1);
    chk("dn_tc", {31'h0, b1.tc}, 32'h1);
    tick_once();
    chk("dn_wrap_0059", {16'h0, b1.cnt}, 32'h0059);
    chk("dn_sat_0000", {16'h0, b0.cnt}, 32'h0);
    up = 1'b1;
    #1;
    chk("up_tc_at_limit", {31'h0, b1.tc}, 32'h1);
    chk("up_tc_sat", {31'h0, b0.tc}, 32'h0);
    tick_once();
    chk("up_wrap_0000", {16'h0, b1.cnt}, 32'h0);
    chk("sat_inc_0001", {16'h0, b0.cnt}, 32'h0001);

    do_load(16'h0020);
    pause = 1'b1;
    repeat (3) tick_once();
    chk("pause_hold", {16'h0, b1.cnt}, 32'h0020);
    pause = 1'b0;
    @(negedge clk); tick_in = 1'b1;
    repeat (10) @(negedge clk);
    tick_in = 1'b0;
    chk("held_one_step", {16'h0, b1.cnt}, 32'h0021);
    en = 1'b0;
    tick_once();
    en = 1'b1;
    chk("en_low_lost", {16'h0, b1.cnt}, 32'h0021);
    @(negedge clk);
    chk("en_low_not_deferred", {16'h0, b1.cnt}, 32'h0021);

    @(negedge clk); load = 1'b1; load_val = 16'h1A3F; tick_in = 1'b1;
    @(negedge clk); load = 1'b0; tick_in = 1'b0;
    chk("clamp_1939", {16'h0, b1.cnt}, 32'h1939);
    chk("clamp_done0", {31'h0, b1.done}, 32'h0);
    @(negedge clk);
    chk("load_no_step", {16'h0, b1.cnt}, 32'h1939);

    @(negedge clk); reset = 1'b1; load = 1'b1; load_val = 16'h1234;
    @(negedge clk); reset = 1'b0; load = 1'b0;
    chk("rst_over_load", {16'h0, b1.cnt}, 32'h0);

    limit = 16'h9999;
    do_load(16'h0456);
    tick_once();
    chk("mid_0457", {16'h0, b1.cnt}, 32'h0457);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_cnt", {16'h0, b1.cnt}, 32'h0);
    chk("mid_rst_done", {31'h0, b1.done}, 32'h0);
    tick_once();
    chk("resume_0001", {16'h0, b1.cnt}, 32'h0001);

    @(negedge clk); reset = 1'b1; tick_in = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); tick_in = 1'b0;
    chk("tick_after_rst", {16'h0, b1.cnt}, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_nd.md
# bcd_counter_nd

Parametrised N-digit BCD game timer/score counter for the Runner design. It runs in the single system clock domain and advances on rising edges of a slow tick strobe from the clock divider. It counts up or down, stops while the game is paused or over, and wraps or saturates at a programmable BCD limit. It drives the seven-segment display path directly and raises terminal-count and done flags for the game FSM.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits; count width is 4*DIGITS.
- WRAP, 1: 1 = wrap at terminal value, 0 = saturate/hold.

Ports:
- clk  in  1: system clock; all state updates on posedge clk.
- reset  in  1: synchronous, active-high; clears all state on the clock edge where it is high.
- tick_in  in  1: raw 1 Hz (or other) strobe from the divider, any duty cycle; edge-detected internally.
- en  in  1: counting enable.
- pause  in  1: freeze counting (game over / pause); overrides en.
- up  in  1: 1 = count up, 0 = count down.
- load  in  1: synchronous load of load_val.
- load_val  in  4*DIGITS: BCD preset value.
- limit  in  4*DIGITS: BCD terminal value for up-count and wrap target for down-count; held static while counting.
- cnt  out  4*DIGITS: current BCD count, digit 0 in bits [3:0].
- tc  out  1: combinational terminal flag, (up & cnt>=limit) | (~up & cnt==0).
- done  out  1: registered one-cycle pulse on the step that reaches the terminal value.

## Operation
- Edge detect: tick_q register follows tick_in every clk. step = tick_in & ~tick_q & en & ~pause.
- Priority per cycle, highest first: reset, load, step, hold.
- Reset: cnt=0, tick_q=0, done=0.
- Load: each digit of load_val is clamped to 9 if it is >9, then written to cnt. done=0. A tick edge in the same cycle is consumed and no step occurs.
- Up step, cnt < limit: ripple BCD increment. A digit at 9 becomes 0 and carries into the next digit. done=1 if the result == limit.
- Up step, cnt >= limit: WRAP=1 gives cnt=0; WRAP=0 holds cnt. done=0 in both cases.
- Down step, cnt > 0: ripple BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. done=1 if the result == 0.
- Down step, cnt == 0: WRAP=1 gives cnt=limit; WRAP=0 holds cnt. done=0 in both cases.
- done is low in every cycle that has no qualifying step.
- Changing up between steps is legal. tc re-evaluates immediately.
- Compare cnt against limit as unsigned BCD words; this ordering equals numeric ordering for valid BCD.
- limit must be valid BCD. If limit contains a digit >9, the behaviour is undefined and need not be checked.

## Timing
- Latency: a tick_in rising edge sampled at clk edge k updates cnt and done at edge k, visible after k. That is one clk from sampled edge to new count.
- At most one step per tick_in rising edge. A tick_in held high produces no further steps.
- pause or en low at the sampling edge discards that tick; it is not deferred.
- reset mid-count takes effect at the next clk edge. tick_q is also cleared, so if tick_in is still high on the first cycle after reset release, it is treated as a rising edge.
- load and reset are level-sensitive. Holding load high holds cnt at the clamped load_val.
- tc is combinational from cnt, up and limit, with no register delay.

## Structure
- Shared package bcd_pkg: BCD_W=4 constant; digit type; function bcd_clamp(digit).
- Sub-module bcd_digit: one decade register with inc, dec, carry_in/borrow_in, carry_out/borrow_out, and load and clear.
  - The top instantiates DIGITS of them in a generate loop, ripple-chained.
  - The top adds edge detection, the limit compare, wrap/saturate select and done.
- Target size: 150-250 lines of RTL total.

## Test plan
- Reset/basic up: DIGITS=4, limit=9999, en=1, up=1, 12 tick edges → cnt 0x0000 through 0x0012. Check 0x0009→0x0010 and that done stays 0.
- Cascade carry and wrap: load 0x0999, one tick → 0x1000. Load 0x9998, tick → 0x9999 with done=1 for exactly one clk. Next tick → 0x0000 (WRAP=1) or 0x9999 held (WRAP=0).
- Programmable limit, down-count: limit=0x0059, up=0, load 0x0001.
  - Tick → 0x0000, done=1, tc=1.
  - Next tick → 0x0059 (WRAP=1).
  - Toggle up=1 at 0x0059 → tc=1 and the next tick wraps to 0.
- Pause/enable/edge rules:
  - pause=1 across 3 tick edges → cnt unchanged.
  - tick_in held high for 10 clks → exactly one step.
  - A tick edge coinciding with en=0 is lost.
- Load priority and clamp:
  - load=1 with load_val=0x1A3F on a tick edge → cnt=0x1939 and no step.
  - reset and load asserted together → cnt=0.
- Reset mid-operation: cnt=0x0457 counting, reset for 1 clk → cnt=0, done=0. Counting resumes from 0x0001 on the next tick edge.
